// File: rtl/tune_player.sv
// tune_player: run-time loaded piezo tune sequencer.
// Plays a table of {half-period, duration} entries as square-wave tones,
// one-shot or looping, on a differential piezo pair.
// Build option: define FAST_SIM_EN to shrink the duration unit by 16x
// (unit = 2^(DUR_SHIFT-4) clocks) so long tunes simulate quickly.
// Handshake: go/stop are level-sampled request strobes; busy is high from
// the cycle after an accepted go until the sequence ends or is stopped.
module tune_player #(
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int PER_W     = 16,
    parameter int DUR_W     = 4,
    parameter int DUR_SHIFT = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PER_W-1:0] wr_per,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             go,
    input  logic             stop,
    input  logic             loop,
    input  logic [AW-1:0]    last_idx,
    output logic             piezo,
    output logic             piezo_n,
    output logic             busy,
    output logic             start_note,
    output logic [AW-1:0]    note_idx,
    output logic             done
);

`ifdef FAST_SIM_EN
    localparam int EFF_SHIFT = DUR_SHIFT - 4;
`else
    localparam int EFF_SHIFT = DUR_SHIFT;
`endif
    localparam int CW = DUR_W + DUR_SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

    state_t             state;
    state_t             state_n;
    logic [PER_W-1:0]   tab_per [DEPTH];
    logic [DUR_W-1:0]   tab_dur [DEPTH];
    logic               loop_r;
    logic [AW-1:0]      last_r;
    logic [PER_W-1:0]   cur_per;
    logic [DUR_W-1:0]   cur_dur;
    logic [PER_W-1:0]   per_cnt;
    logic [CW-1:0]      dur_cnt;
    logic [CW-1:0]      dur_len;
    logic               tone;
    logic               note_last;
    logic               sounding;
    logic               done_n;
    logic               start_seq;
    logic               load;
    logic               inc_idx;
    logic               clr_idx;

    assign dur_len   = CW'(cur_dur) << EFF_SHIFT;
    assign note_last = (dur_cnt == dur_len - CW'(1));
    assign sounding  = (state == S_PLAY) && (cur_per != '0);
    assign piezo     = sounding & tone;
    assign piezo_n   = sounding & ~tone;
    assign busy      = (state != S_IDLE);
    assign start_note = (state == S_PLAY) && (dur_cnt == '0);

    // Note table: plain storage, never reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            tab_per[wr_addr] <= wr_per;
            tab_dur[wr_addr] <= wr_dur;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and control decode; stop overrides everything.
    always_comb begin
        state_n   = state;
        done_n    = 1'b0;
        start_seq = 1'b0;
        load      = 1'b0;
        inc_idx   = 1'b0;
        clr_idx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_n   = S_FETCH;
                    start_seq = 1'b1;
                    clr_idx   = 1'b1;
                end
            end
            S_FETCH: begin
                if (tab_dur[note_idx] == '0) begin
                    // A terminator at entry 0 cannot loop, or it would spin.
                    if (loop_r && note_idx != '0) begin
                        clr_idx = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    load    = 1'b1;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (note_last) begin
                    if (note_idx < last_r) begin
                        inc_idx = 1'b1;
                        state_n = S_FETCH;
                    end else if (loop_r) begin
                        clr_idx = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (stop) begin
            state_n   = S_IDLE;
            done_n    = 1'b0;
            start_seq = 1'b0;
            load      = 1'b0;
            inc_idx   = 1'b0;
            clr_idx   = 1'b1;
        end
    end

    // Datapath: sequence settings, note index, tone and duration counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_r   <= 1'b0;
            last_r   <= '0;
            note_idx <= '0;
            cur_per  <= '0;
            cur_dur  <= '0;
            per_cnt  <= '0;
            dur_cnt  <= '0;
            tone     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= done_n;
            if (start_seq) begin
                loop_r <= loop;
                last_r <= last_idx;
            end
            if (clr_idx)      note_idx <= '0;
            else if (inc_idx) note_idx <= note_idx + AW'(1);
            if (load) begin
                cur_per <= tab_per[note_idx];
                cur_dur <= tab_dur[note_idx];
                per_cnt <= '0;
                dur_cnt <= '0;
                tone    <= 1'b0;
            end else if (state == S_PLAY) begin
                dur_cnt <= dur_cnt + CW'(1);
                if (cur_per != '0) begin
                    if (per_cnt == cur_per - PER_W'(1)) begin
                        per_cnt <= '0;
                        tone    <= ~tone;
                    end else begin
                        per_cnt <= per_cnt + PER_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tune_player.sv
// Bench for tune_player (DUR_SHIFT=4, default build): per-cycle output
// trace from a note-level reference model, plus directed scenarios.
module tb_tune_player;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PER_W = 16;
    localparam int DUR_W = 4;
    localparam int U     = 16;
    localparam int W     = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [PER_W-1:0] wr_per = '0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic             go = 1'b0;
    logic             stop = 1'b0;
    logic             loop = 1'b0;
    logic [AW-1:0]    last_idx = '0;
    logic             piezo, piezo_n, busy, start_note, done;
    logic [AW-1:0]    note_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int dc;
    int m_per [DEPTH];
    int m_dur [DEPTH];
    logic [W-1:0] exp_q[$];

    tune_player #(.DEPTH(DEPTH), .AW(AW), .PER_W(PER_W), .DUR_W(DUR_W), .DUR_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_per(wr_per),
        .wr_dur(wr_dur), .go(go), .stop(stop), .loop(loop), .last_idx(last_idx),
        .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .start_note(start_note),
        .note_idx(note_idx), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit b, input bit s, input bit d,
                                          input bit p, input bit pn, input int idx);
        return {b, s, d, p, pn, AW'(idx)};
    endfunction

    function automatic logic [W-1:0] obs();
        return {busy, start_note, done, piezo, piezo_n, note_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: table write while idle (model follows)
    task automatic wr(input int a, input int p, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_per = PER_W'(p); wr_dur = DUR_W'(d);
        tick();
        wr_en = 1'b0;
        m_per[a] = p;
        m_dur[a] = d;
    endtask

    // reference model: expected outputs for cycles 1..horizon after go
    task automatic build_trace(input bit lp, input int last, input int horizon);
        int idx = 0;
        bit fin = 0;
        exp_q.delete();
        while (!fin && exp_q.size() < horizon) begin
            exp_q.push_back(pack(1, 0, 0, 0, 0, idx));
            if (m_dur[idx] == 0) begin
                if (lp && idx != 0) idx = 0;
                else begin
                    exp_q.push_back(pack(0, 0, 1, 0, 0, idx));
                    fin = 1;
                end
            end else begin
                for (int k = 0; k < m_dur[idx] * U; k++) begin
                    bit pz = (m_per[idx] != 0) && (((k / m_per[idx]) % 2) == 1);
                    exp_q.push_back(pack(1, k == 0, 0, pz, (m_per[idx] != 0) && !pz, idx));
                end
                if (idx < last) idx++;
                else if (lp) idx = 0;
                else begin
                    exp_q.push_back(pack(0, 0, 1, 0, 0, idx));
                    fin = 1;
                end
            end
        end
        while (exp_q.size() < horizon) exp_q.push_back(pack(0, 0, 0, 0, 0, idx));
    endtask

    // driver + scoreboard: one sequence with optional stop / busy write / busy go
    task automatic run_seq(input string tag, input bit lp, input int last, input int horizon,
                           input int stop_at, input int wr_at, input int go_at,
                           input bit go_with_stop, output int done_cyc);
        build_trace(lp, last, horizon);
        if (stop_at > 0)
            for (int j = stop_at; j < exp_q.size(); j++) exp_q[j] = pack(0, 0, 0, 0, 0, 0);
        done_cyc = -1;
        go = 1'b1; loop = lp; last_idx = AW'(last);
        tick();
        go = 1'b0;
        for (int c = 1; c <= horizon; c++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check(tag, 32'(obs()), 32'(e));
            if (done && done_cyc < 0) done_cyc = c;
            stop = (c == stop_at);
            go = (c == go_at) || (c == stop_at && go_with_stop);
            if (c == wr_at) begin
                wr_en = 1'b1;
                wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_per = PER_W'($urandom);
                wr_dur = DUR_W'($urandom);
            end
            tick();
            stop = 1'b0; go = 1'b0; wr_en = 1'b0;
        end
        exp_q.delete();
    endtask

    initial begin
        #2;
        check("reset_state", 32'(obs()), 32'(0));
        tick(); tick();
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 9), $urandom_range(1, 3));

        // one-shot tone then rest
        wr(0, 3, 2); wr(1, 0, 1);
        run_seq("oneshot", 0, 1, 56, 0, 0, 0, 0, dc);
        check("oneshot_done_cycle", 32'(dc), 32'((1 + 2 * U) + (1 + 1 * U) + 1));

        // loop mode, go while busy ignored, stop mid-note
        run_seq("loop_stop", 1, 1, 90, 60, 0, 40, 0, dc);
        check("loop_no_done", 32'(dc), 32'(-1));

        // terminator stops the sequence before entry 2
        wr(0, 5, 1); wr(1, 7, 0); wr(2, 5, 1);
        run_seq("terminator", 0, 2, 24, 0, 0, 0, 0, dc);
        check("term_done_cycle", 32'(dc), 32'(1 + U + 1 + 1));

        // write while busy is dropped; stop together with go wins
        run_seq("busy_write", 1, 2, 30, 20, 1, 0, 1, dc);
        run_seq("replay", 0, 2, 24, 0, 0, 0, 0, dc);
        go = 1'b1; stop = 1'b1;
        tick();
        go = 1'b0; stop = 1'b0;
        check("go_with_stop", 32'(obs()), 32'(0));
        tick();
        check("go_with_stop_2", 32'(obs()), 32'(0));

        // asynchronous reset mid-PLAY, table retained
        wr(0, 3, 2); wr(1, 0, 1);
        go = 1'b1; loop = 1'b0; last_idx = AW'(1);
        tick();
        go = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_busy", 32'(busy), 32'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(obs()), 32'(0));
        tick();
        rst_n = 1'b1;
        run_seq("after_rst", 0, 1, 56, 0, 0, 0, 0, dc);
        check("after_rst_done", 32'(dc), 32'(51));

        // randomized sequences
        for (int r = 0; r < 24; r++) begin
            bit lp;
            int last, hz, sa, ga;
            for (int a = 0; a < 6; a++)
                wr(a, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 9),
                   ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3));
            lp = 1'($urandom_range(0, 1));
            last = $urandom_range(0, 5);
            if (lp) begin
                hz = $urandom_range(60, 300);
                sa = hz - 3;
                ga = (m_dur[0] != 0) ? $urandom_range(2, sa - 1) : 0;
                run_seq("rand_loop", 1, last, hz, sa, 1, ga, 1'($urandom_range(0, 1)), dc);
            end else begin
                run_seq("rand_oneshot", 0, last, 300, 0, 1, 0, 0, dc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
